// File: rtl/ram_arbiter_pkg.sv
// Shared types and helpers for the RAM arbiter.
package ram_arbiter_pkg;

  localparam int unsigned MaxReq = 8;

  function automatic int unsigned id_w(input int unsigned n);
    return (n > 2) ? unsigned'($clog2(n)) : 1;
  endfunction

  localparam int unsigned TagIdW = id_w(MaxReq);

  // Sized for the largest supported requester count; the top narrows the id on use.
  typedef struct packed {
    logic [TagIdW-1:0] id;
    logic              err;
    logic              wr;
  } resp_tag_t;

endpackage

// File: rtl/ram_arbiter_if.sv
// Requester-side bus of ram_arbiter: request handshake plus tagged one-hot response.
interface ram_arbiter_if #(
  parameter int unsigned NUM_REQ = 2
);
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ-1:0]        req_we;
  logic [NUM_REQ-1:0][31:0]  req_addr;
  logic [NUM_REQ-1:0][31:0]  req_wdata;
  logic [NUM_REQ-1:0]        resp_valid;
  logic                      resp_err;
  logic [31:0]               resp_rdata;

  modport master (
    output req_valid, req_we, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_err, resp_rdata
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata,
    output req_ready, resp_valid, resp_err, resp_rdata
  );
endinterface

// File: rtl/ram_arbiter_rr.sv
// Combinational round-robin picker with an optional forced grant for burst hold.
module ram_arbiter_rr #(
  parameter int unsigned N   = 2,
  parameter int unsigned IdW = 1
) (
  input  logic [N-1:0]   req_i,
  input  logic [IdW-1:0] ptr_i,
  input  logic           hold_en_i,
  input  logic [IdW-1:0] hold_id_i,
  output logic [N-1:0]   gnt_o,
  output logic [IdW-1:0] id_o
);

  localparam logic [IdW:0] NVal = (IdW + 1)'(N);

  logic         found;
  logic [IdW:0] sum;

  always_comb begin
    gnt_o = '0;
    id_o  = '0;
    found = 1'b0;
    sum   = '0;
    if (hold_en_i) begin
      gnt_o[hold_id_i] = 1'b1;
      id_o             = hold_id_i;
    end else begin
      for (int unsigned k = 0; k < N; k++) begin
        sum = {1'b0, ptr_i} + (IdW + 1)'(k);
        if (sum >= NVal) sum = sum - NVal;
        if (!found && req_i[IdW'(sum)]) begin
          found               = 1'b1;
          gnt_o[IdW'(sum)]    = 1'b1;
          id_o                = IdW'(sum);
        end
      end
    end
  end

endmodule

// File: rtl/ram_arbiter.sv
// Shares one single-port, 1-cycle-latency word RAM among NUM_REQ requesters using
// round-robin with bounded burst hold; bad accesses are answered with an error response.
module ram_arbiter
  import ram_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ   = 2,
  parameter int unsigned MEM_DEPTH = 16384,
  parameter int unsigned BURST_MAX = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  ram_arbiter_if.slave bus,
  output logic [31:0]  ram_addr_o,
  output logic [31:0]  ram_wdata_o,
  output logic         ram_write_en_o,
  output logic         ram_read_en_o,
  input  logic [31:0]  ram_rdata_i
);

  localparam int unsigned     IdW       = id_w(NUM_REQ);
  localparam int unsigned     CntW      = (BURST_MAX > 1) ? unsigned'($clog2(BURST_MAX)) : 1;
  localparam logic [CntW-1:0] CntMax    = CntW'(BURST_MAX - 1);
  localparam logic [32:0]     AddrLimit = 33'(MEM_DEPTH) << 2;

  logic [IdW-1:0]     rr_ptr_q, rr_ptr_d, owner_q, owner_d, gnt_id;
  logic               owner_vld_q, owner_vld_d, pending_q, pending_d;
  logic [CntW-1:0]    burst_cnt_q, burst_cnt_d;
  resp_tag_t          tag_q, tag_d;
  logic [NUM_REQ-1:0] gnt;
  logic               hold_en, issue, addr_ok, sel_we;
  logic [31:0]        sel_addr, sel_wdata;

  assign hold_en = owner_vld_q && bus.req_valid[owner_q] && (burst_cnt_q < CntMax);

  ram_arbiter_rr #(
    .N   (NUM_REQ),
    .IdW (IdW)
  ) u_rr (
    .req_i     (bus.req_valid),
    .ptr_i     (rr_ptr_q),
    .hold_en_i (hold_en),
    .hold_id_i (owner_q),
    .gnt_o     (gnt),
    .id_o      (gnt_id)
  );

  // Grants are suppressed while in reset so every output reads zero.
  assign issue     = rst_n && (|gnt);
  assign sel_addr  = bus.req_addr[gnt_id];
  assign sel_wdata = bus.req_wdata[gnt_id];
  assign sel_we    = bus.req_we[gnt_id];
  assign addr_ok   = (sel_addr[1:0] == 2'b00) && ({1'b0, sel_addr} < AddrLimit);

  always_comb begin
    bus.req_ready  = issue ? gnt : '0;
    ram_addr_o     = issue ? sel_addr : '0;
    ram_wdata_o    = issue ? sel_wdata : '0;
    ram_write_en_o = issue && addr_ok && sel_we;
    ram_read_en_o  = issue && addr_ok && !sel_we;
  end

  // A response in flight when reset asserts is dropped.
  always_comb begin
    bus.resp_valid = '0;
    bus.resp_err   = 1'b0;
    bus.resp_rdata = '0;
    if (rst_n && pending_q) begin
      bus.resp_valid[IdW'(tag_q.id)] = 1'b1;
      bus.resp_err                   = tag_q.err;
      bus.resp_rdata                 = (tag_q.wr || tag_q.err) ? '0 : ram_rdata_i;
    end
  end

  always_comb begin
    rr_ptr_d    = rr_ptr_q;
    burst_cnt_d = burst_cnt_q;
    owner_d     = owner_q;
    owner_vld_d = owner_vld_q;
    pending_d   = 1'b0;
    tag_d       = tag_q;
    if (issue) begin
      rr_ptr_d = (32'(gnt_id) == NUM_REQ - 1) ? '0 : gnt_id + IdW'(1);
      // Saturate so a lone requester re-granted after its hold expires stays at the limit.
      if (owner_vld_q && (gnt_id == owner_q)) begin
        burst_cnt_d = (burst_cnt_q == CntMax) ? CntMax : burst_cnt_q + CntW'(1);
      end else begin
        burst_cnt_d = '0;
      end
      owner_d     = gnt_id;
      owner_vld_d = 1'b1;
      pending_d   = 1'b1;
      tag_d.id    = TagIdW'(gnt_id);
      tag_d.err   = !addr_ok;
      tag_d.wr    = sel_we;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_ptr_q    <= '0;
      burst_cnt_q <= '0;
      owner_q     <= '0;
      owner_vld_q <= 1'b0;
      pending_q   <= 1'b0;
      tag_q       <= '0;
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      burst_cnt_q <= burst_cnt_d;
      owner_q     <= owner_d;
      owner_vld_q <= owner_vld_d;
      pending_q   <= pending_d;
      tag_q       <= tag_d;
    end
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// Self-checking bench for ram_arbiter: directed scenarios then randomized traffic,
// checked cycle by cycle against a behavioural arbitration/memory model.
module tb_ram_arbiter;

  localparam int unsigned NUM_REQ   = 3;
  localparam int unsigned MEM_DEPTH = 64;
  localparam int unsigned BURST_MAX = 4;
  localparam int unsigned AW        = $clog2(MEM_DEPTH);

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] ram_addr, ram_wdata;
  logic [31:0] ram_rdata = '0;
  logic        ram_write_en, ram_read_en;

  ram_arbiter_if #(.NUM_REQ(NUM_REQ)) bus ();

  ram_arbiter #(
    .NUM_REQ   (NUM_REQ),
    .MEM_DEPTH (MEM_DEPTH),
    .BURST_MAX (BURST_MAX)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .bus            (bus),
    .ram_addr_o     (ram_addr),
    .ram_wdata_o    (ram_wdata),
    .ram_write_en_o (ram_write_en),
    .ram_read_en_o  (ram_read_en),
    .ram_rdata_i    (ram_rdata)
  );

  always #5 clk = ~clk;

  // Registered-read RAM attached to the arbiter.
  logic [31:0] mem [MEM_DEPTH];
  always @(posedge clk) begin
    if (ram_write_en) mem[ram_addr[AW+1:2]] <= ram_wdata;
    if (ram_read_en)  ram_rdata <= mem[ram_addr[AW+1:2]];
  end

  // Reference model state: who owns the bus, how many grants in a row, where RR resumes.
  logic [31:0] ref_mem [MEM_DEPTH];
  int          m_ptr, m_owner, m_streak, m_pid;
  bit          m_pend, m_perr;
  logic [31:0] m_prdata;
  int          n_vec, n_err;
  int          last_dut_g;
  logic [31:0] last_rdata;
  int          grants [10];
  int          exp_burst [10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_ptr = 0; m_owner = -1; m_streak = 0; m_pend = 0; m_pid = 0; m_perr = 0; m_prdata = '0;
  endtask

  function automatic int model_grant();
    int idx;
    if (m_owner >= 0 && bus.req_valid[m_owner] && m_streak < int'(BURST_MAX)) return m_owner;
    for (int k = 0; k < int'(NUM_REQ); k++) begin
      idx = (m_ptr + k) % int'(NUM_REQ);
      if (bus.req_valid[idx]) return idx;
    end
    return -1;
  endfunction

  function automatic logic [31:0] rand_addr();
    int unsigned r = $urandom_range(9);
    int unsigned w = ($urandom_range(1) == 0) ? $urandom_range(7) : $urandom_range(MEM_DEPTH - 1);
    if (r < 7)  return 32'(w * 4);
    if (r == 7) return 32'(w * 4 + $urandom_range(1, 3));
    if (r == 8) return 32'(MEM_DEPTH * 4 + w * 4);
    return $urandom;
  endfunction

  task automatic set_req(input int i, input bit v, input bit we, input logic [31:0] a,
                         input logic [31:0] d);
    bus.req_valid[i] = v;
    bus.req_we[i]    = we;
    bus.req_addr[i]  = a;
    bus.req_wdata[i] = d;
  endtask

  task automatic clear_reqs();
    for (int i = 0; i < int'(NUM_REQ); i++) set_req(i, 1'b0, 1'b0, '0, '0);
  endtask

  // Checks one clock cycle on the falling edge, then advances the model.
  task automatic cycle();
    int                 g;
    bit                 ok, we;
    logic [31:0]        a;
    logic [NUM_REQ-1:0] exp_rdy, exp_rv;
    @(negedge clk);
    g = rst_n ? model_grant() : -1;
    exp_rdy = '0;
    if (g >= 0) exp_rdy[g] = 1'b1;
    ok = 0; we = 0; a = '0;
    if (g >= 0) begin
      a  = bus.req_addr[g];
      we = bus.req_we[g];
      ok = (a[1:0] == 2'b00) && (a < MEM_DEPTH * 4);
    end
    last_dut_g = -1;
    for (int i = 0; i < int'(NUM_REQ); i++) if (bus.req_ready[i]) last_dut_g = i;
    last_rdata = bus.resp_rdata;
    chk("req_ready", 32'(bus.req_ready), 32'(exp_rdy));
    chk("ram_write_en", 32'(ram_write_en), 32'(ok && we));
    chk("ram_read_en", 32'(ram_read_en), 32'(ok && !we));
    if (ok) chk("ram_addr", ram_addr, a);
    if (ok && we) chk("ram_wdata", ram_wdata, bus.req_wdata[g]);
    exp_rv = '0;
    if (rst_n && m_pend) exp_rv[m_pid] = 1'b1;
    chk("resp_valid", 32'(bus.resp_valid), 32'(exp_rv));
    chk("resp_err", 32'(bus.resp_err), 32'(rst_n && m_pend && m_perr));
    chk("resp_rdata", bus.resp_rdata, (rst_n && m_pend) ? m_prdata : 32'h0);
    if (!rst_n) begin
      model_reset();
    end else begin
      m_pend = (g >= 0);
      if (g >= 0) begin
        m_pid    = g;
        m_perr   = !ok;
        m_prdata = (!ok || we) ? 32'h0 : ref_mem[a[AW+1:2]];
        if (ok && we) ref_mem[a[AW+1:2]] = bus.req_wdata[g];
        m_streak = (g == m_owner) ? ((m_streak < int'(BURST_MAX)) ? m_streak + 1 : m_streak) : 1;
        m_owner  = g;
        m_ptr    = (g + 1) % int'(NUM_REQ);
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] v;
    n_vec = 0; n_err = 0; last_dut_g = -1; last_rdata = '0;
    model_reset();
    for (int i = 0; i < int'(MEM_DEPTH); i++) begin
      v = $urandom; mem[i] = v; ref_mem[i] = v;
    end
    mem[4] = 32'hDEADBEEF; ref_mem[4] = 32'hDEADBEEF;
    clear_reqs();
    rst_n = 1'b0;
    @(posedge clk); #1;

    // Reset: outputs stay zero even with requests present.
    cycle();
    for (int i = 0; i < int'(NUM_REQ); i++) set_req(i, 1'b1, 1'b0, 32'h10, '0);
    cycle();
    rst_n = 1'b1;
    clear_reqs();
    cycle();

    // Single read of 0x10.
    set_req(0, 1'b1, 1'b0, 32'h10, '0);
    cycle();
    chk("single_grant", 32'(last_dut_g), 32'(0));
    clear_reqs();
    cycle();
    chk("single_rdata", last_rdata, 32'hDEADBEEF);

    // Burst hold: req1 backs off one cycle after each grant.
    rst_n = 1'b0; cycle(); rst_n = 1'b1;
    set_req(0, 1'b1, 1'b0, 32'h0, '0);
    set_req(1, 1'b1, 1'b0, 32'h4, '0);
    for (int c = 0; c < 10; c++) begin
      cycle();
      grants[c] = last_dut_g;
      bus.req_valid[1] = (last_dut_g != 1);
    end
    for (int c = 0; c < 10; c++) chk("burst_seq", 32'(grants[c]), 32'(exp_burst[c]));
    clear_reqs();
    cycle();

    // Misaligned and out-of-range accesses.
    set_req(2, 1'b1, 1'b0, 32'h13, '0);
    cycle();
    set_req(2, 1'b1, 1'b1, 32'(MEM_DEPTH * 4), 32'hAAAA5555);
    cycle();
    clear_reqs();
    cycle();

    // Write then read of the same word from different requesters.
    set_req(1, 1'b1, 1'b1, 32'h20, 32'h12345678);
    cycle();
    clear_reqs();
    set_req(0, 1'b1, 1'b0, 32'h20, '0);
    cycle();
    chk("write_resp_rdata", last_rdata, 32'h0);
    clear_reqs();
    cycle();
    chk("read_after_write", last_rdata, 32'h12345678);

    // Reset in the cycle after issue drops the response; RR restarts at 0.
    set_req(0, 1'b1, 1'b0, 32'h10, '0);
    cycle();
    clear_reqs();
    rst_n = 1'b0;
    cycle();
    rst_n = 1'b1;
    for (int i = 0; i < int'(NUM_REQ); i++) set_req(i, 1'b1, 1'b0, 32'(i * 4), '0);
    cycle();
    chk("post_reset_grant", 32'(last_dut_g), 32'(0));
    clear_reqs();
    cycle();

    // Randomized traffic; a request is held until granted.
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < int'(NUM_REQ); i++) begin
        if (!bus.req_valid[i] || last_dut_g == i) begin
          if ($urandom_range(2) != 0) set_req(i, 1'b1, 1'($urandom_range(1)), rand_addr(), $urandom);
          else bus.req_valid[i] = 1'b0;
        end
      end
      rst_n = ($urandom_range(99) != 0);
      cycle();
    end
    rst_n = 1'b1;
    clear_reqs();
    cycle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
